// File: rtl/leve1_if.sv
`default_nettype none
// ============================================================================
//  Module   : leve1_if
//  Purpose  : Level-1 instruction fetch front end. Issues sequential fetches,
//             pairs in-order responses with their PCs, buffers two decoded-ready
//             instructions and discards in-flight responses after a redirect.
//  Revision : 1.0  initial release
// ============================================================================
module leve1_if #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h8000_0000)
) (
    input  logic            CLK,
    input  logic            RSTn,
    output logic            IMEM_AVALID,
    input  logic            IMEM_AREADY,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_RVALID,
    input  logic [31:0]     IMEM_RDATA,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [XLEN-1:0] OPC,
    output logic [31:0]     OINSTR,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] FLUSH_PC
);

    logic [XLEN-1:0] pc;
    logic [1:0]      outstanding;
    logic [1:0]      drop;
    logic [1:0]      fifo_count;

    logic [XLEN-1:0] pcq_mem [2];
    logic            pcq_rd;
    logic            pcq_wr;

    logic [XLEN-1:0] fifo_pc    [2];
    logic [31:0]     fifo_instr [2];
    logic            fifo_rd;
    logic            fifo_wr;

    logic [2:0] credit_sum;
    logic [2:0] in_flight;
    logic [2:0] drop_after_flush;
    logic       req_fire;
    logic       rsp_drop;
    logic       rsp_take;
    logic       push;
    logic       pop;

    assign credit_sum = {1'b0, outstanding} + {1'b0, drop} + {1'b0, fifo_count};
    assign in_flight  = {1'b0, outstanding} + {1'b0, drop};

    // Credits cover every slot a response could land in, so the buffer
    // can never overflow and no back-pressure toward memory is needed.
    assign IMEM_AVALID = RSTn && !FLUSH && (credit_sum < 3'd2);
    assign IMEM_ADDR   = pc;
    assign req_fire    = IMEM_AVALID && IMEM_AREADY;

    // A response with nothing outstanding and nothing to drop is ignored.
    assign rsp_drop = IMEM_RVALID && (drop != 2'd0);
    assign rsp_take = IMEM_RVALID && (drop == 2'd0) && (outstanding != 2'd0);

    assign push = rsp_take && !FLUSH;
    assign pop  = OVALID && OREADY && !FLUSH;

    assign drop_after_flush = in_flight - ((rsp_drop || rsp_take) ? 3'd1 : 3'd0);

    assign OVALID = (fifo_count != 2'd0);
    assign OPC    = fifo_pc[fifo_rd];
    assign OINSTR = fifo_instr[fifo_rd];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc          <= RESET_VEC;
            outstanding <= 2'd0;
            drop        <= 2'd0;
            fifo_count  <= 2'd0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            pcq_rd      <= 1'b0;
            pcq_wr      <= 1'b0;
        end else if (FLUSH) begin
            pc          <= FLUSH_PC;
            outstanding <= 2'd0;
            drop        <= drop_after_flush[1:0];
            fifo_count  <= 2'd0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            pcq_rd      <= 1'b0;
            pcq_wr      <= 1'b0;
        end else begin
            if (req_fire) begin
                pc     <= pc + XLEN'(4);
                pcq_wr <= ~pcq_wr;
            end
            if (rsp_take) begin
                pcq_rd <= ~pcq_rd;
            end
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_take};
            if (rsp_drop) begin
                drop <= drop - 2'd1;
            end
            if (push) begin
                fifo_wr <= ~fifo_wr;
            end
            if (pop) begin
                fifo_rd <= ~fifo_rd;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage carries no reset; it is only observed behind OVALID.
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= pc;
        end
        if (push) begin
            fifo_pc[fifo_wr]    <= pcq_mem[pcq_rd];
            fifo_instr[fifo_wr] <= IMEM_RDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leve1_if.sv
`default_nettype none
// Testbench for leve1_if: randomized memory/decode stimulus against a
// queue-based reference of in-flight requests and buffered instructions.
module tb_leve1_if;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        IMEM_AVALID;
    logic        IMEM_AREADY = 1'b0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'd0;
    logic        OVALID;
    logic        OREADY = 1'b0;
    logic [31:0] OPC;
    logic [31:0] OINSTR;
    logic        FLUSH = 1'b0;
    logic [31:0] FLUSH_PC = 32'd0;

    leve1_if #(.XLEN(32), .RESET_VEC(RV)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .IMEM_AVALID(IMEM_AVALID), .IMEM_AREADY(IMEM_AREADY), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .OVALID(OVALID), .OREADY(OREADY), .OPC(OPC), .OINSTR(OINSTR),
        .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        memq[$];
    logic [31:0] bufq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_due = 0;
    int aready_pct = 100;
    int oready_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int accepted = 0;
    int dropped = 0;
    int delivered = 0;
    bit spurious = 0;
    bit flush_on_collide = 0;
    bit collide_hit = 0;
    bit saw_wrap = 0;
    logic [31:0] flush_target = 32'd0;
    logic [31:0] fetch_exp = RV;
    logic [31:0] stream_exp = RV;
    logic [31:0] prev_acc = 32'd0;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic plan_inputs();
        IMEM_AREADY = ($urandom_range(99) < aready_pct);
        OREADY      = ($urandom_range(99) < oready_pct);
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = word_of(memq[0].addr);
        end else if (spurious && memq.size() == 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = 32'hDEAD_BEEF;
            spurious    = 0;
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = $urandom;
        end
        FLUSH    = 1'b0;
        FLUSH_PC = $urandom;
        if (flush_on_collide && IMEM_RVALID && bufq.size() != 0) begin
            OREADY           = 1'b1;
            FLUSH            = 1'b1;
            FLUSH_PC         = flush_target;
            flush_on_collide = 0;
            collide_hit      = 1;
        end
    endtask

    task automatic observe();
        int lat;
        int due;
        chk("avalid", IMEM_AVALID, !FLUSH && (memq.size() + bufq.size() < 2));
        chk("ovalid", OVALID, bufq.size() != 0);
        if (OVALID && bufq.size() != 0) begin
            chk("opc", OPC, bufq[0]);
            chk("oinstr", OINSTR, word_of(bufq[0]));
        end
        if (FLUSH) begin
            foreach (memq[i]) memq[i].stale = 1;
            if (IMEM_RVALID && memq.size() != 0) begin
                void'(memq.pop_front());
                dropped++;
            end
            bufq.delete();
            fetch_exp  = FLUSH_PC;
            stream_exp = FLUSH_PC;
        end else begin
            if (OVALID && OREADY && bufq.size() != 0) begin
                chk("stream", OPC, stream_exp);
                stream_exp += 32'd4;
                delivered++;
                void'(bufq.pop_front());
            end
            if (IMEM_RVALID && memq.size() != 0) begin
                req_t e = memq.pop_front();
                if (e.stale) dropped++;
                else bufq.push_back(e.addr);
            end
            if (IMEM_AVALID && IMEM_AREADY) begin
                chk("addr", IMEM_ADDR, fetch_exp);
                if (fetch_exp == 32'd0 && prev_acc == 32'hFFFF_FFFC) saw_wrap = 1;
                prev_acc = fetch_exp;
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{fetch_exp, 1'b0, due});
                fetch_exp += 32'd4;
                accepted++;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        if (RSTn) begin
            observe();
        end else begin
            chk("rst_avalid", IMEM_AVALID, 1'b0);
            chk("rst_ovalid", OVALID, 1'b0);
            chk("rst_addr", IMEM_ADDR, RV);
        end
        @(posedge CLK);
        #1;
        cyc++;
        plan_inputs();
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        memq.delete();
        bufq.delete();
        fetch_exp        = RV;
        stream_exp       = RV;
        last_due         = 0;
        spurious         = 0;
        flush_on_collide = 0;
        FLUSH            = 1'b0;
        repeat (2) step();
        RSTn = 1'b1;
    endtask

    initial begin
        int a0;
        int d0;
        int n;

        // Back-to-back fetch with single-cycle memory
        do_reset();
        repeat (12) step();

        // Decode stalled: two fetches fill the buffer, then requests stop
        do_reset();
        oready_pct = 0;
        a0 = accepted;
        repeat (10) step();
        chk("stall_reqs", accepted - a0, 2);
        chk("stall_avalid", IMEM_AVALID, 1'b0);
        chk("stall_opc", OPC, RV);
        spurious = 1;
        repeat (3) step();
        oready_pct = 100;
        repeat (10) step();

        // Redirect with two requests still in flight
        do_reset();
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (!(memq.size() == 2 && !memq[0].stale && !memq[1].stale && !IMEM_RVALID) && n < 20) begin
            step();
            n++;
        end
        chk("flush2_reached", n < 20, 1'b1);
        d0 = dropped;
        a0 = delivered;
        FLUSH    = 1'b1;
        FLUSH_PC = 32'h0000_0100;
        repeat (12) step();
        chk("flush2_dropped", dropped - d0, 2);
        chk("flush2_delivered", delivered - a0 > 0, 1'b1);

        // Redirect colliding with a response and a decode handshake
        do_reset();
        lat_min = 1;
        lat_max = 2;
        flush_target     = 32'h0000_2000;
        collide_hit      = 0;
        flush_on_collide = 1;
        n = 0;
        while (!collide_hit && n < 200) begin
            step();
            n++;
        end
        chk("collide_hit", collide_hit, 1'b1);
        repeat (10) step();

        // Address wrap at the top of the space
        do_reset();
        lat_min  = 1;
        lat_max  = 1;
        saw_wrap = 0;
        step();
        FLUSH    = 1'b1;
        FLUSH_PC = 32'hFFFF_FFF8;
        repeat (12) step();
        chk("wrap_seen", saw_wrap, 1'b1);

        // Random memory timing, random decode stalls, occasional redirects
        do_reset();
        aready_pct = 50;
        oready_pct = 70;
        lat_min    = 1;
        lat_max    = 5;
        d0 = delivered;
        n  = 0;
        while (delivered - d0 < 1000 && n < 30000) begin
            step();
            if ($urandom_range(99) == 0) begin
                FLUSH    = 1'b1;
                FLUSH_PC = $urandom & 32'hFFFF_FFFC;
            end
            n++;
        end
        chk("rand_delivered", delivered - d0 >= 1000, 1'b1);

        // Asynchronous reset in the middle of traffic
        #2;
        RSTn = 1'b0;
        #1;
        chk("areset_ovalid", OVALID, 1'b0);
        chk("areset_avalid", IMEM_AVALID, 1'b0);
        chk("areset_addr", IMEM_ADDR, RV);
        do_reset();
        aready_pct = 100;
        oready_pct = 100;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
